// File: rtl/dv_checkpoint_monitor.sv
// dv_checkpoint_monitor
// Synchronises and debounces an asynchronous checkpoint bus and tracks the
// start -> pass/fail code sequence. It also provides a cycle timeout, a
// saturating step counter and a sticky verdict.
// Optional build macro: CHKMON_ORDER_EN. When it is defined, every step code
// accepted in RUN must be unsigned-greater than the previously accepted code.
module dv_checkpoint_monitor #(
    parameter int CW         = 16,
    parameter int STABLE_CYC = 2,
    parameter int TW         = 32,
    parameter int SW         = 8
) (
    input  logic          mclk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [CW-1:0] checkbits,
    input  logic [CW-1:0] cfg_start,
    input  logic [CW-1:0] cfg_pass,
    input  logic [CW-1:0] cfg_fail,
    input  logic [TW-1:0] cfg_timeout,
    output logic          started,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_reason,
    output logic [SW-1:0] step_cnt,
    output logic [CW-1:0] last_code
);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, RUN, PASS, FAIL, TMO
    } state_t;

    localparam logic [1:0] FR_NONE  = 2'd0;
    localparam logic [1:0] FR_CODE  = 2'd1;
    localparam logic [1:0] FR_TMO   = 2'd2;
`ifdef CHKMON_ORDER_EN
    localparam logic [1:0] FR_ORDER = 2'd3;
`endif

    localparam int            SCW      = $clog2(STABLE_CYC + 1);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYC);

    // Input path: synchroniser, stability tracker, one-shot acceptance.
    logic [CW-1:0]  sync1_q, sync2_q, cand_q, acc_code_q;
    logic [CW-1:0]  cand_d, acc_code_d;
    logic [SCW-1:0] stab_cnt_q, stab_cnt_d;
    logic           acc_valid_q, acc_valid_d, accept_q, accept_d;

    // Monitor state.
    state_t         state_q, state_d;
    logic           started_q, started_d;
    logic [1:0]     fail_reason_q, fail_reason_d;
    logic [SW-1:0]  step_cnt_q, step_cnt_d;
    logic [CW-1:0]  last_code_q, last_code_d;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic           tmo_hit;

    // Debounce the synchronised bus and raise a single accept pulse when a new
    // value has been stable long enough. The "already accepted" memory is
    // dropped while disabled, so a held code is accepted again after re-arming.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cand_d = sync2_q;
        if (sync2_q != cand_q)
            stab_cnt_d = SCW'(1);
        else if (stab_cnt_q != STAB_MAX)
            stab_cnt_d = stab_cnt_q + 1'b1;
        else
            stab_cnt_d = stab_cnt_q;
        accept_d    = enable && (stab_cnt_q == STAB_MAX) &&
                      (!acc_valid_q || (cand_q != acc_code_q));
        acc_code_d  = accept_d ? cand_q : acc_code_q;
        acc_valid_d = enable && (acc_valid_q || accept_d);
    end

    // Register the input path. The two sync flops are the only place where
    // checkbits enters the mclk domain.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            stab_cnt_q  <= '0;
            acc_code_q  <= '0;
            acc_valid_q <= 1'b0;
            accept_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q     <= checkbits;
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            stab_cnt_q  <= stab_cnt_d;
            acc_code_q  <= acc_code_d;
            acc_valid_q <= acc_valid_d;
            accept_q    <= accept_d;
        end
    end

    // Next-state logic. An accepted pass/fail code (or an order violation)
    // beats a timeout in the same cycle. Any other code loses to the timeout:
    // last_code still records it, but neither started nor step_cnt moves.
    always_comb begin
        state_d       = state_q;
        started_d     = started_q;
        fail_reason_d = fail_reason_q;
        step_cnt_d    = step_cnt_q;
        last_code_d   = last_code_q;
        tmo_cnt_d     = tmo_cnt_q;
        tmo_hit       = 1'b0;
        if (!enable) begin
            state_d       = IDLE;
            started_d     = 1'b0;
            fail_reason_d = FR_NONE;
            step_cnt_d    = '0;
            last_code_d   = '0;
            tmo_cnt_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = WAIT_START;
                    tmo_cnt_d = '0;
                end
                WAIT_START, RUN: begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    tmo_hit   = (cfg_timeout != '0) && (tmo_cnt_d == cfg_timeout);
                    if (accept_q) begin
                        last_code_d = acc_code_q;
                        if (state_q == WAIT_START) begin
                            if (acc_code_q == cfg_start) begin
                                state_d   = RUN;
                                started_d = 1'b1;
                            end
                        end else if (acc_code_q == cfg_pass) begin
                            state_d = PASS;
                        end else if (acc_code_q == cfg_fail) begin
                            state_d       = FAIL;
                            fail_reason_d = FR_CODE;
`ifdef CHKMON_ORDER_EN
                        end else if (acc_code_q <= last_code_q) begin
                            state_d       = FAIL;
                            fail_reason_d = FR_ORDER;
`endif
                        end else if (step_cnt_q != '1) begin
                            step_cnt_d = step_cnt_q + 1'b1;
                        end
                    end
                    if (tmo_hit && (state_d == WAIT_START || state_d == RUN)) begin
                        state_d       = TMO;
                        fail_reason_d = FR_TMO;
                        started_d     = started_q;
                        step_cnt_d    = step_cnt_q;
                    end
                end
                default: ; // PASS/FAIL/TMO are terminal: everything frozen
            endcase
        end
    end

    // Register the monitor state.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            started_q     <= 1'b0;
            fail_reason_q <= FR_NONE;
            step_cnt_q    <= '0;
            last_code_q   <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            started_q     <= started_d;
            fail_reason_q <= fail_reason_d;
            step_cnt_q    <= step_cnt_d;
            last_code_q   <= last_code_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign started     = started_q;
    assign pass        = (state_q == PASS);
    assign fail        = (state_q == FAIL) || (state_q == TMO);
    assign done        = pass || fail;
    assign fail_reason = fail_reason_q;
    assign step_cnt    = step_cnt_q;
    assign last_code   = last_code_q;

endmodule

// File: tb/tb_dv_checkpoint_monitor.sv
// tb_dv_checkpoint_monitor
// Directed scenarios plus randomised episodes. Each one is compared every cycle
// against a behavioural model that works from a bus history and verdict flags.
// The model tracks the CHKMON_ORDER_EN build macro.
module tb_dv_checkpoint_monitor;

    localparam int CW = 16;
    localparam int S  = 2;
    localparam int TW = 32;
    localparam int SW = 8;
    localparam int STEP_MAX = (1 << SW) - 1;

    logic          mclk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] checkbits;
    logic [CW-1:0] cfg_start, cfg_pass, cfg_fail;
    logic [TW-1:0] cfg_timeout;
    logic          started, done, pass, fail;
    logic [1:0]    fail_reason;
    logic [SW-1:0] step_cnt;
    logic [CW-1:0] last_code;

    dv_checkpoint_monitor #(.CW(CW), .STABLE_CYC(S), .TW(TW), .SW(SW)) dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .enable      (enable),
        .checkbits   (checkbits),
        .cfg_start   (cfg_start),
        .cfg_pass    (cfg_pass),
        .cfg_fail    (cfg_fail),
        .cfg_timeout (cfg_timeout),
        .started     (started),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .fail_reason (fail_reason),
        .step_cnt    (step_cnt),
        .last_code   (last_code)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [CW-1:0] hist[$];          // bus value seen at each edge
    bit            mem_valid;        // a code has been accepted since arming
    logic [CW-1:0] mem_code;
    bit            pend;             // acceptance the monitor acts on next edge
    logic [CW-1:0] pend_code;
    bit            m_armed, m_started;
    int            m_verdict;        // 0 none, 1 pass, 2 fail code/order, 3 timeout
    int            m_reason, m_steps;
    logic [CW-1:0] m_last;
    longint        m_elapsed;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 3; i++) hist.push_back('0);
        mem_valid = 0; mem_code = '0; pend = 0; pend_code = '0;
        m_armed = 0; m_started = 0; m_verdict = 0; m_reason = 0;
        m_steps = 0; m_last = '0; m_elapsed = 0;
    endtask

    task automatic model_step();
        bit            acc, tmo, decided, stable;
        logic [CW-1:0] code, prev, cand;
        acc  = pend;
        code = pend_code;
        if (!enable) begin
            m_armed = 0; m_started = 0; m_verdict = 0; m_reason = 0;
            m_steps = 0; m_last = '0; m_elapsed = 0;
        end else if (!m_armed) begin
            m_armed = 1; m_elapsed = 0;
        end else if (m_verdict == 0) begin
            m_elapsed++;
            tmo     = (cfg_timeout != 0) && (m_elapsed == longint'(cfg_timeout));
            decided = 0;
            if (acc) begin
                prev   = m_last;
                m_last = code;
                if (!m_started) begin
                    if (code == cfg_start && !tmo) m_started = 1;
                end else if (code == cfg_pass) begin
                    m_verdict = 1; decided = 1;
                end else if (code == cfg_fail) begin
                    m_verdict = 2; m_reason = 1; decided = 1;
`ifdef CHKMON_ORDER_EN
                end else if (code <= prev) begin
                    m_verdict = 2; m_reason = 3; decided = 1;
`endif
                end else if (!tmo && m_steps < STEP_MAX) begin
                    m_steps++;
                end
            end
            if (tmo && !decided) begin
                m_verdict = 3; m_reason = 2;
            end
        end
        // A bus value is accepted S+3 edges after its first sampling edge if
        // it was seen on S consecutive edges and differs from the last accepted code.
        hist.push_back(checkbits);
        while (hist.size() > S + 3) void'(hist.pop_front());
        cand   = hist[hist.size() - 4];
        stable = 1;
        for (int j = 0; j < S; j++)
            if (hist[hist.size() - 4 - j] != cand) stable = 0;
        pend      = enable && stable && (!mem_valid || cand != mem_code);
        pend_code = cand;
        if (pend) mem_code = cand;
        mem_valid = enable && (mem_valid || pend);
    endtask

    task automatic check_outputs();
        check("started",     32'(started),     32'(m_started));
        check("done",        32'(done),        32'(m_verdict != 0));
        check("pass",        32'(pass),        32'(m_verdict == 1));
        check("fail",        32'(fail),        32'(m_verdict >= 2));
        check("fail_reason", 32'(fail_reason), 32'(m_reason));
        check("step_cnt",    32'(step_cnt),    32'(m_steps));
        check("last_code",   32'(last_code),   32'(m_last));
    endtask

    task automatic tick();
        @(posedge mclk);
        model_step();
        @(negedge mclk);
        check_outputs();
    endtask

    task automatic hold(input logic [CW-1:0] v, input int n);
        checkbits = v;
        repeat (n) tick();
    endtask

    task automatic disarm();
        enable = 1'b0;
        repeat (3) tick();
    endtask

    task automatic run_full_pass(input string tag);
        enable = 1'b1;
        hold(16'hAB60, 10);
        for (int i = 1; i <= 9; i++) hold(16'hAB60 + 16'(i), 10);
        hold(16'hAB6A, 10);
        check({tag, "_started"}, 32'(started), 32'd1);
        check({tag, "_pass"},    32'(pass),    32'd1);
        check({tag, "_done"},    32'(done),    32'd1);
        check({tag, "_fail"},    32'(fail),    32'd0);
        check({tag, "_steps"},   32'(step_cnt), 32'd9);
        check({tag, "_last"},    32'(last_code), 32'hAB6A);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; checkbits = '0;
        cfg_start = 16'hAB60; cfg_pass = 16'hAB6A; cfg_fail = 16'hAB6F; cfg_timeout = '0;
        model_reset();
        #12;
        check_outputs();
        check("rst_step", 32'(step_cnt), 32'd0);
        @(negedge mclk) reset_n = 1'b1;
        repeat (4) tick();

        // Full pass sequence.
        run_full_pass("t1");

        // Fail code, then a later pass code is ignored.
        disarm();
        enable = 1'b1;
        hold(16'hAB60, 10);
        hold(16'hAB6F, 10);
        check("t2_fail",   32'(fail), 32'd1);
        check("t2_reason", 32'(fail_reason), 32'd1);
        check("t2_steps",  32'(step_cnt), 32'd0);
        hold(16'hAB6A, 10);
        check("t2_pass_ignored", 32'(pass), 32'd0);
        check("t2_last_frozen",  32'(last_code), 32'hAB6F);

        // Timeout at exactly 100 cycles after the enable edge.
        disarm();
        cfg_timeout = 100;
        checkbits   = 16'h1234;
        enable      = 1'b1;
        tick();
        repeat (99) tick();
        check("t3_done_at_99", 32'(done), 32'd0);
        tick();
        check("t3_done_at_100", 32'(done), 32'd1);
        check("t3_fail",   32'(fail), 32'd1);
        check("t3_reason", 32'(fail_reason), 32'd2);

        // Timeout disabled.
        disarm();
        cfg_timeout = 0;
        enable = 1'b1;
        hold(16'h1234, 300);
        check("t3b_no_tmo", 32'(done), 32'd0);

        // One-cycle glitch to the pass code is filtered.
        disarm();
        enable = 1'b1;
        hold(16'hAB60, 10);
        hold(16'hAB61, 10);
        hold(16'hAB6A, 1);
        hold(16'hAB61, 10);
        check("t4_glitch_done", 32'(done), 32'd0);
        check("t4_glitch_steps", 32'(step_cnt), 32'd1);

        // Pass accepted on the very timeout cycle wins.
        disarm();
        cfg_timeout = 40;
        checkbits   = 16'hAB60;
        enable      = 1'b1;
        tick();
        repeat (34) tick();
        checkbits = 16'hAB6A;
        repeat (5) tick();
        check("t4_race_pre", 32'(done), 32'd0);
        tick();
        check("t4_race_pass",   32'(pass), 32'd1);
        check("t4_race_fail",   32'(fail), 32'd0);
        check("t4_race_reason", 32'(fail_reason), 32'd0);

        // Abort mid-run, then re-arm and pass again.
        disarm();
        cfg_timeout = 0;
        enable = 1'b1;
        hold(16'hAB60, 10);
        for (int i = 1; i <= 3; i++) hold(16'hAB60 + 16'(i), 10);
        check("t5_steps", 32'(step_cnt), 32'd3);
        enable = 1'b0;
        tick();
        check("t5_abort_started", 32'(started), 32'd0);
        check("t5_abort_steps",   32'(step_cnt), 32'd0);
        check("t5_abort_last",    32'(last_code), 32'd0);
        run_full_pass("t5_rerun");

        // Out-of-order step code.
        disarm();
        enable = 1'b1;
        hold(16'hAB60, 10);
        hold(16'hAB63, 10);
        hold(16'hAB62, 10);
`ifdef CHKMON_ORDER_EN
        check("t6_fail",   32'(fail), 32'd1);
        check("t6_reason", 32'(fail_reason), 32'd3);
        check("t6_steps",  32'(step_cnt), 32'd1);
`else
        check("t6_steps",  32'(step_cnt), 32'd2);
        check("t6_done",   32'(done), 32'd0);
`endif

        // Asynchronous reset in the middle of a run.
        disarm();
        enable = 1'b1;
        hold(16'hAB60, 10);
        hold(16'hAB61, 10);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("rst_mid_started", 32'(started), 32'd0);
        @(negedge mclk) reset_n = 1'b1;
        repeat (4) tick();

        // Randomised episodes over a small code alphabet.
        for (int ep = 0; ep < 40; ep++) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            cfg_start   = 16'hAB60 + 16'($urandom_range(0, 15));
            cfg_pass    = 16'hAB60 + 16'($urandom_range(0, 15));
            cfg_fail    = 16'hAB60 + 16'($urandom_range(0, 15));
            cfg_timeout = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(15, 250));
            enable = 1'b1;
            for (int seg = 0; seg < int'($urandom_range(5, 40)); seg++) begin
                int            r;
                logic [CW-1:0] v;
                r = int'($urandom_range(0, 99));
                if (r < 25)      v = cfg_start;
                else if (r < 35) v = cfg_pass;
                else if (r < 45) v = cfg_fail;
                else if (r < 50) v = CW'($urandom);
                else             v = 16'hAB60 + 16'($urandom_range(0, 15));
                hold(v, int'($urandom_range(1, 8)));
                if ($urandom_range(0, 99) < 3) begin
                    enable = 1'b0;
                    repeat ($urandom_range(1, 2)) tick();
                    enable = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
